// File: rtl/canon_89_fold_pkg.sv
// Shared constants, state encoding and fold-correction helper for the 89-bit prime field.
package fp89_pkg;

    localparam int FP89_W     = 89;
    localparam int FP89_RED_W = 92;

    localparam logic [88:0] P89 = 89'h19F393CFFFFFFFFFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        CSUB,
        DONE
    } canon_state_t;

    // M*2^88 mod P, built by repeated modular addition of 2^88 (which is itself < P)
    function automatic logic [88:0] fold_corr(input logic [3:0] m);
        logic [88:0] acc;
        logic [88:0] gap;
        acc = '0;
        gap = P89 - {1'b1, 88'b0};
        for (int i = 0; i < 15; i++) begin
            if (i < int'(m)) begin
                if (acc >= gap) begin
                    acc = acc - gap;
                end else begin
                    acc = acc + {1'b1, 88'b0};
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/canon_89_fold_lut.sv
// Correction table: corr_add = M*2^88 mod P for the four top bits of a redundant operand.
module sub_89_lut
    import fp89_pkg::*;
(
    input  logic [3:0]        m,
    output logic [FP89_W-1:0] corr_add
);

    logic [FP89_W-1:0] lut_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_tab
        assign lut_tab[g] = fold_corr(4'(g));
    end

    assign corr_add = lut_tab[m];

endmodule

// File: rtl/canon_89_fold.sv
// Iterative canonicaliser: folds a 92-bit redundant value into [0, P) with a ready/valid handshake.
// Optional macro CANON89_ITER_CNT_EN adds the fold_cnt output and an iteration-overflow check.
module canon_89_fold
    import fp89_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP89_RED_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP89_W-1:0]     out_data,
`ifdef CANON89_ITER_CNT_EN
    output logic [3:0]            fold_cnt,
`endif
    output logic                  busy
);

    canon_state_t          state;
    logic [FP89_RED_W-1:0] x;
    logic [FP89_W-1:0]     corr_add;

`ifdef CANON89_ITER_CNT_EN
    logic [3:0] iter;
    assign fold_cnt = iter;
`endif

    sub_89_lut u_lut (
        .m        (x[91:88]),
        .corr_add (corr_add)
    );

    // Only M >= 2 is folded; M = 1 leaves a value below 2^89 that CSUB can finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef CANON89_ITER_CNT_EN
            iter      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x        <= in_data;
                        state    <= FOLD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef CANON89_ITER_CNT_EN
                        iter     <= '0;
`endif
                    end
                end
                FOLD: begin
                    if (x[91:89] != 3'b000) begin
                        x <= {4'b0000, x[87:0]} + {3'b000, corr_add};
`ifdef CANON89_ITER_CNT_EN
                        if (iter != 4'hF) begin
                            iter <= iter + 4'd1;
                        end
`endif
                    end else begin
                        state <= CSUB;
                    end
                end
                CSUB: begin
                    out_data  <= (x[88:0] >= P89) ? (x[88:0] - P89) : x[88:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CANON89_ITER_CNT_EN
    a_iter_bound: assert property (@(posedge clk) disable iff (rst)
        !(state == FOLD && x[91:89] != 3'b000 && iter == 4'hF));
`endif

endmodule

// File: tb/tb_canon_89_fold.sv
// Self-checking bench for canon_89_fold: directed boundaries, stall, mid-fold reset and random operands.
module tb_canon_89_fold;

    localparam logic [95:0] P96    = {7'b0, 89'h19F393CFFFFFFFFFFFFFFFF};
    localparam logic [95:0] TWO88  = 96'(1) << 88;
    localparam logic [95:0] TWO89  = 96'(1) << 89;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [91:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [88:0] out_data;
    logic        busy;
`ifdef CANON89_ITER_CNT_EN
    logic [3:0]  fold_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    canon_89_fold dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef CANON89_ITER_CNT_EN
        .fold_cnt  (fold_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: residue by plain modulo; fold count by repeatedly trading the top nibble for its value mod P
    function automatic void refModel(input logic [91:0] d, output logic [95:0] res, output int folds);
        logic [95:0] v;
        logic [95:0] m;
        v     = {4'b0, d};
        folds = 0;
        while (v >= TWO89) begin
            m     = v / TWO88;
            v     = (v % TWO88) + ((m * TWO88) % P96);
            folds++;
        end
        res = {4'b0, d} % P96;
    endfunction

    // Latency counts clock edges with the accepting edge as 1; out_valid is expected at 3 + folds
    task automatic applyStimulus(input logic [91:0] d, input int holdCycles);
        logic [95:0] expRes;
        int          expFolds;
        int          n;
        int          lat;
        logic [88:0] held;
        refModel(d, expRes, expFolds);
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 96'(in_ready), 96'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("out_valid", 96'(out_valid), 96'(1));
        checkOutput("out_data", 96'(out_data), expRes);
        checkOutput("below_p", 96'(96'(out_data) < P96), 96'(1));
        checkOutput("latency", 96'(lat), 96'(3 + expFolds));
`ifdef CANON89_ITER_CNT_EN
        checkOutput("fold_cnt", 96'(fold_cnt), 96'(expFolds > 15 ? 15 : expFolds));
`endif
        if (holdCycles > 0) begin
            held     = out_data;
            in_valid = 1'b1;
            in_data  = 92'd7;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkOutput("stall_data", 96'(out_data), 96'(held));
                checkOutput("stall_valid", 96'(out_valid), 96'(1));
                checkOutput("stall_in_ready", 96'(in_ready), 96'(0));
                checkOutput("stall_busy", 96'(busy), 96'(1));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("release_valid", 96'(out_valid), 96'(0));
        checkOutput("release_in_ready", 96'(in_ready), 96'(1));
        if (holdCycles > 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("no_stray_accept", 96'(busy), 96'(0));
            end
        end
    endtask

    initial begin
        logic [91:0] r;
        logic [95:0] rr;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 96'(in_ready), 96'(1));
        checkOutput("rst_out_valid", 96'(out_valid), 96'(0));
        checkOutput("rst_out_data", 96'(out_data), 96'(0));
        checkOutput("rst_busy", 96'(busy), 96'(0));
`ifdef CANON89_ITER_CNT_EN
        checkOutput("rst_fold_cnt", 96'(fold_cnt), 96'(0));
`endif
        rst = 1'b0;

        applyStimulus(92'd0, 0);
        applyStimulus(92'(P96), 0);
        applyStimulus(92'(P96 - 96'd1), 0);
        applyStimulus(92'(TWO88), 0);
        applyStimulus(92'(TWO89), 0);
        checkOutput("two89_const", 96'(out_data), 96'h60c6c30000000000000001);
        applyStimulus(92'(TWO88 * 96'd3), 0);
        checkOutput("three88_const", 96'(out_data), 96'h160c6c30000000000000001);
        applyStimulus({92{1'b1}}, 0);

        applyStimulus(92'h123456789ABCDEF0123, 5);

        // Reset while folding the all-ones operand
        @(negedge clk);
        in_data  = {92{1'b1}};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre_rst_busy", 96'(busy), 96'(1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 96'(out_valid), 96'(0));
        checkOutput("midrst_in_ready", 96'(in_ready), 96'(1));
        checkOutput("midrst_out_data", 96'(out_data), 96'(0));
        checkOutput("midrst_busy", 96'(busy), 96'(0));
        rst = 1'b0;
        applyStimulus(92'd5, 0);

        for (int k = 0; k < 3000; k++) begin
            rr = {$urandom, $urandom, $urandom};
            r  = rr[91:0];
            if ((k % 4) == 0) begin
                r[91:89] = 3'b000;
            end
            applyStimulus(r, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
